// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample format, I2S frame geometry and
// the slot bit-select used by the serialiser.
package audio_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int SLOT_W      = 32;
  localparam int FRAME_BCLKS = 64;
  localparam int BIT_CNT_W   = $clog2(FRAME_BCLKS);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  // Bit transmitted at slot position idx: one-BCLK I2S delay, MSB first,
  // zero padding after the LSB.
  function automatic logic slot_bit(input sample_t s, input logic [4:0] idx);
    logic [3:0] pos;
    pos = 4'(5'd16 - idx);
    if (idx >= 5'd1 && idx <= 5'd16) return s[pos];
    return 1'b0;
  endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample handshake between the upstream filter and the I2S serialiser.
interface i2s_transmitter_if;
  import audio_pkg::*;

  sample_t left_sample_in;
  sample_t right_sample_in;
  logic    valid_in;
  logic    ready_out;

  modport master (output left_sample_in, right_sample_in, valid_in, input ready_out);
  modport slave  (input left_sample_in, right_sample_in, valid_in, output ready_out);

endinterface

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock generator: divides clk_in into BCLK, flags each falling
// BCLK edge one cycle ahead and tracks the bit position within the frame.
module i2s_clk_gen import audio_pkg::*; #(
  parameter int CLK_DIV = 12
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  output logic                 bclk,
  output logic                 fall_stb,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_tc;

  assign div_tc   = (div_cnt == DIV_LAST);
  // High in the cycle whose clock edge drives BCLK low.
  assign fall_stb = div_tc && bclk;

  // Divider, BCLK toggle and bit counter; bit_cnt resets to 63 so the first
  // fall event opens a frame.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_n_in) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '1;
    end else begin
      if (div_tc) begin
        div_cnt <= '0;
        bclk    <= !bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall_stb) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: one pending stereo pair, loaded into the active
// registers at each frame start and shifted out MSB first, one BCLK after
// each LRCLK edge.
module i2s_transmitter import audio_pkg::*; #(
  parameter int CLK_DIV = 12
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  i2s_transmitter_if.slave         smp_if,
  output logic                     i2s_bclk_out,
  output logic                     i2s_lrclk_out,
  output logic                     i2s_data_out,
  output logic                     frame_start_out,
  output logic                     underrun_out,
  output logic                     overflow_out
);

  logic                 bclk;
  logic                 fall_stb;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_nxt;
  logic                 load_now;
  logic                 accept;
  logic                 full;
  stereo_t              pending;
  stereo_t              active;
  logic [4:0]           idx;
  sample_t              slot_smp;

  i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bclk     (bclk),
    .fall_stb (fall_stb),
    .bit_cnt  (bit_cnt)
  );

  assign i2s_bclk_out     = bclk;
  assign bit_nxt          = bit_cnt + BIT_CNT_W'(1);
  assign load_now         = fall_stb && (bit_nxt == '0);
  // The pending slot frees up on the load edge, so a pair may land there
  // in the very cycle the old one moves to the active registers.
  assign smp_if.ready_out = !full || load_now;
  assign accept           = smp_if.valid_in && smp_if.ready_out;

  // Select the slot sample and bit position for the bit about to start.
  always_comb begin
    // NOTE: every always_comb output gets a value up front so no latch is inferred.
    idx      = bit_nxt[BIT_CNT_W-2:0];
    slot_smp = active.left;
    if (bit_nxt[BIT_CNT_W-1]) slot_smp = active.right;
  end

  // Pending sample storage; validity lives in full, so the data needs no reset.
  always_ff @(posedge clk_in) begin
    // NOTE: data-only registers stay unreset; the full flag qualifies them.
    if (accept) pending <= '{left: smp_if.left_sample_in, right: smp_if.right_sample_in};
  end

  // Frame load, serial outputs and sticky status flags.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      full            <= 1'b0;
      active          <= '0;
      i2s_lrclk_out   <= 1'b0;
      i2s_data_out    <= 1'b0;
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
      overflow_out    <= 1'b0;
    end else begin
      frame_start_out <= load_now;

      if (smp_if.valid_in && !smp_if.ready_out) overflow_out <= 1'b1;

      if (load_now) begin
        if (full) active <= pending;
        else      underrun_out <= 1'b1;
      end

      if (accept)        full <= 1'b1;
      else if (load_now) full <= 1'b0;

      if (fall_stb) begin
        i2s_lrclk_out <= bit_nxt[BIT_CNT_W-1];
        i2s_data_out  <= slot_bit(slot_smp, idx);
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at CLK_DIV = 12: clocking, bit pattern,
// underrun hold, overflow, load/accept collision and mid-frame reset.
module tb_i2s_transmitter;
  import audio_pkg::*;

  localparam int CLK_DIV    = 12;
  localparam int BCLK_CLKS  = 2 * CLK_DIV;
  localparam int FRAME_CLKS = 128 * CLK_DIV;
  localparam int SIG_BCLK   = 0;
  localparam int SIG_LRCLK  = 1;
  localparam int SIG_FS     = 2;
  localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic i2s_bclk_out, i2s_lrclk_out, i2s_data_out;
  logic frame_start_out, underrun_out, overflow_out;

  int checks = 0;
  int errors = 0;
  int cyc;

  i2s_transmitter_if smp_if ();

  i2s_transmitter #(.CLK_DIV(CLK_DIV)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .smp_if          (smp_if),
    .i2s_bclk_out    (i2s_bclk_out),
    .i2s_lrclk_out   (i2s_lrclk_out),
    .i2s_data_out    (i2s_data_out),
    .frame_start_out (frame_start_out),
    .underrun_out    (underrun_out),
    .overflow_out    (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  // Clock number since reset release: after posedge k, cyc == k.
  always @(posedge clk_in) begin
    if (!rst_n_in) cyc <= 0;
    else           cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] out_vec();
    return {i2s_bclk_out, i2s_lrclk_out, i2s_data_out, frame_start_out,
            underrun_out, overflow_out, smp_if.ready_out};
  endfunction

  function automatic logic get_sig(input int sel);
    case (sel)
      SIG_BCLK:  return i2s_bclk_out;
      SIG_LRCLK: return i2s_lrclk_out;
      default:   return frame_start_out;
    endcase
  endfunction

  // Hold reset for n clocks, confirm reset values, then release.
  task automatic apply_reset(input int n, input string tag);
    rst_n_in               = 1'b0;
    smp_if.valid_in        = 1'b0;
    smp_if.left_sample_in  = '0;
    smp_if.right_sample_in = '0;
    repeat (n) @(negedge clk_in);
    check(tag, 64'(out_vec()), 64'b0000001);
    rst_n_in = 1'b1;
  endtask

  task automatic wait_level(input int sel, input logic level, input int budget, input string tag);
    int n = 0;
    while (get_sig(sel) !== level && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, "_in_time"}, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_until_cyc(input int target, input string tag);
    int n = 0;
    while (cyc < target && n < 4 * FRAME_CLKS) begin
      @(negedge clk_in);
      n++;
    end
    check(tag, 64'(cyc), 64'(target));
  endtask

  task automatic send_pair(input sample_t l, input sample_t r);
    smp_if.left_sample_in  = l;
    smp_if.right_sample_in = r;
    smp_if.valid_in        = 1'b1;
    @(negedge clk_in);
    smp_if.valid_in        = 1'b0;
  endtask

  // Waits for a frame start, then samples data/LRCLK mid-way through each bit.
  // Bit b of the frame lands at position 63-b.
  task automatic capture_frame(input string tag, output logic [63:0] data_bits,
                               output logic [63:0] lr_bits, output logic ur_at_start);
    wait_level(SIG_FS, 1'b1, 2 * FRAME_CLKS, tag);
    ur_at_start = underrun_out;
    for (int b = 0; b < 64; b++) begin
      if (b > 0) repeat (BCLK_CLKS) @(negedge clk_in);
      data_bits[63-b] = i2s_data_out;
      lr_bits[63-b]   = i2s_lrclk_out;
    end
  endtask

  task automatic check_frame(input string tag, input logic [63:0] exp_data, input logic exp_ur);
    logic [63:0] d, lr;
    logic        ur;
    capture_frame(tag, d, lr, ur);
    check({tag, "_data"}, d, exp_data);
    check({tag, "_lrclk"}, lr, LR_EXP);
    check({tag, "_underrun"}, 64'(ur), 64'(exp_ur));
  endtask

  initial begin
    int t_lr;

    // Reset and clocking
    apply_reset(5, "t1_reset_state");
    check("t1_release_state", 64'(out_vec()), 64'b0000001);
    wait_level(SIG_BCLK, 1'b1, 4 * BCLK_CLKS, "t1_bclk_rise1");
    check("t1_bclk_rise1_cyc", 64'(cyc), 64'd12);
    wait_level(SIG_FS, 1'b1, 4 * BCLK_CLKS, "t1_fs");
    check("t1_fs_cyc", 64'(cyc), 64'd24);
    check("t1_bclk_low_at_fs", 64'(i2s_bclk_out), 64'd0);
    check("t1_underrun_no_pair", 64'(underrun_out), 64'd1);
    wait_level(SIG_BCLK, 1'b1, 4 * BCLK_CLKS, "t1_bclk_rise2");
    check("t1_bclk_rise2_cyc", 64'(cyc), 64'd36);
    wait_level(SIG_LRCLK, 1'b1, 2 * FRAME_CLKS, "t1_lr_rise1");
    check("t1_lr_rise1_cyc", 64'(cyc), 64'd792);
    t_lr = cyc;
    wait_level(SIG_LRCLK, 1'b0, 2 * FRAME_CLKS, "t1_lr_fall");
    check("t1_lr_fall_cyc", 64'(cyc), 64'd1560);
    wait_level(SIG_LRCLK, 1'b1, 2 * FRAME_CLKS, "t1_lr_rise2");
    check("t1_lr_period", 64'(cyc - t_lr), 64'd1536);

    // Bit pattern: L=8001, R=7FFE -> {0,L,15'b0} / {0,R,15'b0}
    apply_reset(3, "t2_reset_state");
    send_pair(16'h8001, 16'h7FFE);
    check_frame("t2_f1", 64'h4000_8000_3FFF_0000, 1'b0);
    check("t2_overflow", 64'(overflow_out), 64'd0);

    // Underrun hold: one pair, then three frames of the same pattern
    apply_reset(3, "t3_reset_state");
    send_pair(16'h1234, 16'hABCD);
    check_frame("t3_f1", 64'h091A_0000_55E6_8000, 1'b0);
    check_frame("t3_f2", 64'h091A_0000_55E6_8000, 1'b1);
    check_frame("t3_f3", 64'h091A_0000_55E6_8000, 1'b1);

    // Overflow: second pulse 10 clocks later is dropped
    apply_reset(3, "t4_reset_state");
    send_pair(16'h00FF, 16'hFF00);
    repeat (9) @(negedge clk_in);
    check("t4_ready_when_full", 64'(smp_if.ready_out), 64'd0);
    send_pair(16'h5555, 16'hAAAA);
    check("t4_overflow", 64'(overflow_out), 64'd1);
    check_frame("t4_f1", 64'h007F_8000_7F80_0000, 1'b0);

    // Simultaneous load and accept on the load_now cycle
    apply_reset(3, "t5_reset_state");
    send_pair(16'h0001, 16'hFFFF);
    wait_until_cyc(22, "t5_reach_22");
    check("t5_ready_full", 64'(smp_if.ready_out), 64'd0);
    @(negedge clk_in);
    check("t5_ready_load_now", 64'(smp_if.ready_out), 64'd1);
    send_pair(16'h7FFF, 16'h8000);
    check_frame("t5_f1", 64'h0000_8000_7FFF_8000, 1'b0);
    check_frame("t5_f2", 64'h3FFF_8000_4000_0000, 1'b0);
    check("t5_overflow", 64'(overflow_out), 64'd0);

    // Mid-frame reset at bit_cnt = 40 with a pair pending and overflow set
    apply_reset(3, "t6_reset_state");
    send_pair(16'h1234, 16'hABCD);
    send_pair(16'h5555, 16'hAAAA);
    wait_level(SIG_FS, 1'b1, 2 * FRAME_CLKS, "t6_fs");
    @(negedge clk_in);
    send_pair(16'h1111, 16'h2222);
    wait_until_cyc(990, "t6_reach_bit40");
    check("t6_pre_reset", 64'({i2s_lrclk_out, overflow_out, smp_if.ready_out}), 64'b110);
    apply_reset(1, "t6_mid_reset_state");
    check_frame("t6_f1_zero", 64'h0, 1'b1);
    send_pair(16'h0F0F, 16'hF0F0);
    check_frame("t6_f2", 64'h0787_8000_7878_0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
